// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus arbiter slice.
// FSM state encoding, port indices and bus direction encoding.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic PORT_I    = 1'b0;
  localparam logic PORT_D    = 1'b1;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

endpackage

// File: rtl/cpu_bus_watchdog.sv
// Bus-wait watchdog: counts enabled cycles, flags the one reaching TIMEOUT.
// Ports: i_clock, i_reset (sync, low), i_clear, i_enable -> o_expired.
module cpu_bus_watchdog #(
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam bit ARMED = (TIMEOUT != 0);
  localparam int LAST_I = ARMED ? TIMEOUT - 1 : 0;
  localparam logic [TIMEOUT_WIDTH-1:0] LAST =
    TIMEOUT_WIDTH'(LAST_I);
  localparam logic [TIMEOUT_WIDTH-1:0] ONE =
    TIMEOUT_WIDTH'(1);

  logic [TIMEOUT_WIDTH-1:0] count_q;
  logic [TIMEOUT_WIDTH-1:0] count_d;

  // Expiry fires in the cycle whose increment would reach
  // TIMEOUT, so the abort lands after exactly TIMEOUT waits.
  assign o_expired = ARMED && i_enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expired) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one CPU memory bus between fetch (I, read) and data (D, r/w).
// Ports: i_clock, i_reset, fetch/data request sides, o_bus_*/i_bus_*, o_error.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  input  logic [31:0] i_fetch_address,
  output logic [31:0] o_fetch_rdata,
  output logic        o_fetch_ready,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  output logic [31:0] o_data_rdata,
  output logic        o_data_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic        o_error
);

  localparam bit D_FIRST = (DATA_PRIORITY != 0);

  state_e      state_q, state_d;
  logic        winner_q, winner_d;
  logic        rr_q, rr_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_rw_q, bus_rw_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic        f_ready_q, f_ready_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_ready_q, d_ready_d;
  logic        error_q, error_d;

  logic        pick;
  logic        win_req;
  logic        wd_en;
  logic        wd_clr;
  logic        wd_exp;
  logic [31:0] rd_val;

  assign wd_en  = (state_q == ST_BUSY) && !i_bus_ready;
  assign wd_clr = (state_q != ST_BUSY);

  cpu_bus_watchdog #(
    .TIMEOUT       (TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (wd_clr),
    .i_enable  (wd_en),
    .o_expired (wd_exp)
  );

  // rr_q names the port that wins the next tie; it flips
  // away from each winner so the last winner loses.
  always_comb begin
    pick = PORT_I;
    unique case (1'b1)
      (i_data_request && !i_fetch_request): pick = PORT_D;
      (i_fetch_request && !i_data_request): pick = PORT_I;
      default: pick = D_FIRST ? PORT_D : rr_q;
    endcase
  end

  assign win_req = (winner_q == PORT_D) ? i_data_request
                                        : i_fetch_request;

  // Writes and aborts return zero read data.
  assign rd_val = (i_bus_ready && bus_rw_q == BUS_READ)
                ? i_bus_rdata : 32'h0;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_d        = rr_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    f_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    error_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_fetch_request || i_data_request) begin
          winner_d  = pick;
          rr_d      = ~pick;
          bus_req_d = 1'b1;
          state_d   = ST_BUSY;
          if (pick == PORT_D) begin
            bus_rw_d    = i_data_rw;
            bus_addr_d  = i_data_address;
            bus_wdata_d = i_data_wdata;
          end else begin
            bus_rw_d    = BUS_READ;
            bus_addr_d  = i_fetch_address;
            bus_wdata_d = 32'h0;
          end
        end
      end
      ST_BUSY: begin
        if (i_bus_ready || wd_exp) begin
          bus_req_d = 1'b0;
          error_d   = !i_bus_ready;
          state_d   = ST_RELEASE;
          if (winner_q == PORT_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = rd_val;
          end else begin
            f_ready_d = 1'b1;
            f_rdata_d = rd_val;
          end
        end
      end
      ST_RELEASE: begin
        if (!win_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      winner_q    <= PORT_I;
      rr_q        <= PORT_I;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= BUS_READ;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      f_rdata_q   <= 32'h0;
      f_ready_q   <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_ready_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_q        <= rr_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      f_rdata_q   <= f_rdata_d;
      f_ready_q   <= f_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
      error_q     <= error_d;
    end
  end

  assign o_fetch_rdata = f_rdata_q;
  assign o_fetch_ready = f_ready_q;
  assign o_data_rdata  = d_rdata_q;
  assign o_data_ready  = d_ready_q;
  assign o_bus_request = bus_req_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter.
// dut_a: D priority, TIMEOUT=4; dut_b: round-robin, no watchdog.
module tb_cpu_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_req;
  logic        data_rw;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  logic [31:0] a_f_rdata, a_d_rdata, a_addr, a_wdata;
  logic        a_f_ready, a_d_ready, a_req, a_rw, a_err;
  logic [31:0] b_f_rdata, b_d_rdata, b_addr, b_wdata;
  logic        b_f_ready, b_d_ready, b_req, b_rw, b_err;

  int checks;
  int failures;

  cpu_bus_arbiter #(
    .DATA_PRIORITY (1),
    .TIMEOUT       (4),
    .TIMEOUT_WIDTH (8)
  ) u_dut_a (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_fetch_request (fetch_req),
    .i_fetch_address (fetch_addr),
    .o_fetch_rdata   (a_f_rdata),
    .o_fetch_ready   (a_f_ready),
    .i_data_request  (data_req),
    .i_data_rw       (data_rw),
    .i_data_address  (data_addr),
    .i_data_wdata    (data_wdata),
    .o_data_rdata    (a_d_rdata),
    .o_data_ready    (a_d_ready),
    .o_bus_request   (a_req),
    .o_bus_rw        (a_rw),
    .o_bus_address   (a_addr),
    .o_bus_wdata     (a_wdata),
    .i_bus_rdata     (bus_rdata),
    .i_bus_ready     (bus_ready),
    .o_error         (a_err)
  );

  cpu_bus_arbiter #(
    .DATA_PRIORITY (0),
    .TIMEOUT       (0),
    .TIMEOUT_WIDTH (8)
  ) u_dut_b (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_fetch_request (fetch_req),
    .i_fetch_address (fetch_addr),
    .o_fetch_rdata   (b_f_rdata),
    .o_fetch_ready   (b_f_ready),
    .i_data_request  (data_req),
    .i_data_rw       (data_rw),
    .i_data_address  (data_addr),
    .i_data_wdata    (data_wdata),
    .o_data_rdata    (b_d_rdata),
    .o_data_ready    (b_d_ready),
    .o_bus_request   (b_req),
    .o_bus_rw        (b_rw),
    .o_bus_address   (b_addr),
    .o_bus_wdata     (b_wdata),
    .i_bus_rdata     (bus_rdata),
    .i_bus_ready     (bus_ready),
    .o_error         (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    data_req   = 1'b0;
    data_rw    = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    bus_rdata  = 32'h0;
    bus_ready  = 1'b0;
    tick();
    tick();
    check("rst_req", a_req, 0);
    check("rst_fready", a_f_ready, 0);
    check("rst_dready", a_d_ready, 0);
    check("rst_addr", a_addr, 0);
    check("rst_err", a_err, 0);
    check("rst_b_req", b_req, 0);
    rst_n = 1'b1;
    tick();

    // 1: fetch read, ready in 3rd busy cycle
    fetch_req  = 1'b1;
    fetch_addr = 32'h100;
    tick();
    check("t1_req", a_req, 1);
    check("t1_addr", a_addr, 32'h100);
    check("t1_rw", a_rw, 0);
    check("t1_wdata", a_wdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t1_hold_req", a_req, 1);
      check("t1_hold_rw", a_rw, 0);
      check("t1_no_ready", a_f_ready, 0);
    end
    bus_ready = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    tick();
    check("t1_ready", a_f_ready, 1);
    check("t1_rdata", a_f_rdata, 32'hDEADBEEF);
    check("t1_err", a_err, 0);
    check("t1_req_drop", a_req, 0);
    bus_ready = 1'b0;
    fetch_req = 1'b0;
    tick();
    check("t1_pulse", a_f_ready, 0);
    check("t1_rhold", a_f_rdata, 32'hDEADBEEF);

    // 2: D write beats simultaneous I
    data_req   = 1'b1;
    data_rw    = 1'b1;
    data_addr  = 32'h2000;
    data_wdata = 32'h12345678;
    fetch_req  = 1'b1;
    fetch_addr = 32'h300;
    tick();
    check("t2_req", a_req, 1);
    check("t2_rw", a_rw, 1);
    check("t2_addr", a_addr, 32'h2000);
    check("t2_wdata", a_wdata, 32'h12345678);
    bus_ready = 1'b1;
    bus_rdata = 32'hAAAA5555;
    tick();
    check("t2_dready", a_d_ready, 1);
    check("t2_drdata", a_d_rdata, 0);
    check("t2_fready", a_f_ready, 0);
    bus_ready = 1'b0;
    data_req  = 1'b0;
    tick();
    check("t2_gap", a_req, 0);
    tick();
    check("t2_i_req", a_req, 1);
    check("t2_i_addr", a_addr, 32'h300);
    check("t2_i_rw", a_rw, 0);
    check("t2_i_wdata", a_wdata, 0);
    bus_ready = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    tick();
    check("t2_i_ready", a_f_ready, 1);
    check("t2_i_rdata", a_f_rdata, 32'hCAFEF00D);
    bus_ready = 1'b0;
    fetch_req = 1'b0;
    tick();

    // 4: watchdog abort after 4 busy cycles
    fetch_req  = 1'b1;
    fetch_addr = 32'h400;
    tick();
    check("t4_req", a_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wait_req", a_req, 1);
      check("t4_wait_err", a_err, 0);
      check("t4_wait_rdy", a_f_ready, 0);
    end
    tick();
    check("t4_abort_req", a_req, 0);
    check("t4_abort_rdy", a_f_ready, 1);
    check("t4_abort_err", a_err, 1);
    check("t4_abort_rd", a_f_rdata, 0);
    fetch_req = 1'b0;
    tick();
    check("t4_err_pulse", a_err, 0);
    data_req  = 1'b1;
    data_rw   = 1'b0;
    data_addr = 32'h500;
    tick();
    check("t4_next_req", a_req, 1);
    check("t4_next_rw", a_rw, 0);
    check("t4_next_addr", a_addr, 32'h500);
    bus_ready = 1'b1;
    bus_rdata = 32'h0BADF00D;
    tick();
    check("t4_next_rdy", a_d_ready, 1);
    check("t4_next_rd", a_d_rdata, 32'h0BADF00D);
    check("t4_next_err", a_err, 0);
    bus_ready = 1'b0;
    data_req  = 1'b0;
    tick();

    // 5: reset while busy
    fetch_req  = 1'b1;
    fetch_addr = 32'h600;
    tick();
    check("t5_req", a_req, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_req", a_req, 0);
    check("t5_rst_addr", a_addr, 0);
    check("t5_rst_frdy", a_f_ready, 0);
    check("t5_rst_drd", a_d_rdata, 0);
    check("t5_rst_err", a_err, 0);
    rst_n = 1'b1;
    tick();
    check("t5_regrant", a_req, 1);
    check("t5_re_addr", a_addr, 32'h600);
    bus_ready = 1'b1;
    bus_rdata = 32'h11112222;
    tick();
    check("t5_ready", a_f_ready, 1);
    check("t5_rdata", a_f_rdata, 32'h11112222);

    // 6: request held after ready; stray bus_ready ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_req", a_req, 0);
      check("t6_no_rdy", a_f_ready, 0);
    end
    bus_ready = 1'b0;
    fetch_req = 1'b0;
    tick();
    check("t6_idle_req", a_req, 0);
    tick();
    check("t6_idle_req2", a_req, 0);

    // 3: round-robin on dut_b
    rst_n = 1'b0;
    tick();
    check("t3_rst_req", b_req, 0);
    rst_n      = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h700;
    data_req   = 1'b1;
    data_rw    = 1'b0;
    data_addr  = 32'h800;
    for (int n = 0; n < 4; n++) begin
      int   w;
      logic is_i;
      logic [31:0] exp_a;
      is_i  = (n % 2 == 0);
      exp_a = is_i ? 32'h700 : 32'h800;
      w = 0;
      while (!b_req && w < 8) begin
        tick();
        w++;
      end
      check("t3_grant", b_req, 1);
      check("t3_addr", b_addr, exp_a);
      bus_ready = 1'b1;
      bus_rdata = 32'h1000 + n;
      tick();
      bus_ready = 1'b0;
      check("t3_frdy", b_f_ready, is_i);
      check("t3_drdy", b_d_ready, !is_i);
      if (is_i) begin
        check("t3_frd", b_f_rdata, 32'h1000 + n);
        fetch_req = 1'b0;
      end else begin
        check("t3_drd", b_d_rdata, 32'h1000 + n);
        data_req = 1'b0;
      end
      tick();
      fetch_req = 1'b1;
      data_req  = 1'b1;
    end
    fetch_req = 1'b0;
    data_req  = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
